spi_periph_core: RTL and testbench

Synthesizable SPI peripheral (secondary) endpoint, the responder counterpart to `spi_core`. It oversamples the incoming `sclk`, `ss_n` and `mosi` on the system clock. It shifts received bits into a parallel word, presented as a one-cycle strobe, and shifts out a word supplied through a one-entry transmit buffer with a valid/ready handshake. It sits between the board SPI pins and the local register or FIFO logic of a device that is addressed by an `spi_core` master.

---
 rtl/spi_periph_core.sv | 189 ++++++++++++++++++
 tb/tb_spi_periph_core.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_periph_core.sv
// SPI mode-0 peripheral endpoint, MSB first.
// Oversamples sclk/ss_n/mosi on clk; one-entry tx buffer, rx strobe out.
module spi_periph_core #(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DWIDTH-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DWIDTH-1:0] rx_data,
    output logic              rx_valid,
    output logic              underrun,
    output logic              busy
);

    localparam int CW = $clog2(DWIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(DWIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0]        sclk_q;
    logic [2:0]        ss_q;
    logic [1:0]        mosi_q;

    logic              sclk_rise;
    logic              sclk_fall;
    logic              ss_fall;
    logic              ss_rise;
    logic              mosi_s;

    logic              do_load;
    logic              do_rx;
    logic              do_tx;
    logic              do_abort;

    logic [DWIDTH-1:0] tx_buf;
    logic              tx_full;
    logic [DWIDTH-1:0] tx_sh;
    logic [DWIDTH-1:0] rx_sh;
    logic [CW-1:0]     cnt;
    logic [DWIDTH-1:0] rx_next;

    // Two-flop synchronizers plus a third stage on sclk/ss_n for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            ss_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            ss_q   <= {ss_q[1:0], ss_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ss_fall   = ~ss_q[1] & ss_q[2];
    assign ss_rise   = ss_q[1] & ~ss_q[2];
    assign mosi_s    = mosi_q[1];

    assign rx_next   = {rx_sh[DWIDTH-2:0], mosi_s};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle action decode; deselect beats any sclk event.
    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_rx     = 1'b0;
        do_tx     = 1'b0;
        do_abort  = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt = SHIFT;
                    do_load   = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    do_abort  = 1'b1;
                end else if (sclk_rise) begin
                    do_rx = 1'b1;
                end else if (sclk_fall) begin
                    if (cnt != '0) begin
                        do_tx = 1'b1;
                    end else begin
                        do_load = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One-entry transmit buffer; a load can only drain a full buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf  <= '0;
            tx_full <= 1'b0;
        end else if (do_load && tx_full) begin
            tx_full <= 1'b0;
        end else if (tx_valid && !tx_full) begin
            tx_buf  <= tx_data;
            tx_full <= 1'b1;
        end
    end

    assign tx_ready = ~tx_full;

    // Transmit shifter and registered miso.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh    <= '0;
            miso     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (do_abort) begin
                tx_sh <= '0;
                miso  <= 1'b0;
            end else if (do_load) begin
                if (tx_full) begin
                    tx_sh <= tx_buf;
                    miso  <= tx_buf[DWIDTH-1];
                end else begin
                    tx_sh    <= '0;
                    miso     <= 1'b0;
                    underrun <= 1'b1;
                end
            end else if (do_tx) begin
                tx_sh <= {tx_sh[DWIDTH-2:0], 1'b0};
                miso  <= tx_sh[DWIDTH-2];
            end
        end
    end

    // Receive shifter, bit counter and completed-word strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh    <= '0;
            cnt      <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (do_abort) begin
                rx_sh <= '0;
                cnt   <= '0;
            end else if (do_rx) begin
                rx_sh <= rx_next;
                if (cnt == LAST) begin
                    cnt      <= '0;
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign miso_oe = (state == SHIFT);
    assign busy    = (state == SHIFT);

endmodule

// File: tb/tb_spi_periph_core.sv
// Scoreboard bench for spi_periph_core: expected rx and miso words are
// queued by the stimulus and popped by a monitor on each rx_valid.
module tb_spi_periph_core;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       underrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0;
    int un_cnt = 0;

    logic [7:0] miso_cap = '0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    spi_periph_core #(.DWIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .underrun (underrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every rx_valid strobe consumes one expected rx and miso word.
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            rxv_cnt++;
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %0h, expected no strobe",
                         rx_data);
            end else begin
                check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
                if (tx_q.size() != 0)
                    check("miso_word", 32'(miso_cap), 32'(tx_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && underrun) un_cnt++;
    end

    task automatic push_tx(input logic [7:0] d);
        int n;
        n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL tx_ready_timeout: got 0, expected 1");
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_after_accept", 32'(tx_ready), 32'd0);
    endtask

    // Master: n bits MSB first, sclk = clk/10; leaves sclk high afterwards.
    task automatic spi_bits(input logic [7:0] d, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            if (sclk) sclk = 1'b0;
            mosi = d[i];
            clks(5);
            miso_cap = {miso_cap[6:0], miso};
            sclk = 1'b1;
            clks(5);
        end
    endtask

    task automatic start_xfer();
        ss_n = 1'b0;
        clks(8);
    endtask

    // Deselect while sclk is still high, so no trailing word load happens.
    task automatic end_xfer();
        clks(2);
        ss_n = 1'b1;
        clks(3);
        sclk = 1'b0;
        clks(4);
    endtask

    initial begin
        int rv0;
        rst_n    = 1'b0;
        sclk     = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        clks(3);

        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        clks(4);

        // Basic transfer.
        push_tx(8'hA5);
        rx_q.push_back(8'h3C);
        tx_q.push_back(8'hA5);
        start_xfer();
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_miso_oe", 32'(miso_oe), 32'd1);
        check("basic_tx_ready_reload", 32'(tx_ready), 32'd1);
        check("basic_miso_msb", 32'(miso), 32'd1);
        spi_bits(8'h3C, 8);
        end_xfer();
        check("basic_busy_end", 32'(busy), 32'd0);
        check("basic_oe_end", 32'(miso_oe), 32'd0);
        check("basic_miso_end", 32'(miso), 32'd0);
        check("basic_rx_held", 32'(rx_data), 32'h3C);
        check("basic_rxv_cnt", 32'(rxv_cnt), 32'd1);
        check("basic_underrun", 32'(un_cnt), 32'd0);

        // Back-to-back words.
        push_tx(8'h81);
        rx_q.push_back(8'h11);
        tx_q.push_back(8'h81);
        rx_q.push_back(8'h22);
        tx_q.push_back(8'h7E);
        start_xfer();
        push_tx(8'h7E);
        spi_bits(8'h11, 8);
        spi_bits(8'h22, 8);
        end_xfer();
        check("b2b_rxv_cnt", 32'(rxv_cnt), 32'd3);
        check("b2b_underrun", 32'(un_cnt), 32'd0);
        check("b2b_rx_data", 32'(rx_data), 32'h22);

        // Underrun: nothing preloaded.
        rx_q.push_back(8'hFF);
        tx_q.push_back(8'h00);
        start_xfer();
        check("ur_pulse", 32'(un_cnt), 32'd1);
        spi_bits(8'hFF, 8);
        end_xfer();
        check("ur_once", 32'(un_cnt), 32'd1);
        check("ur_rx_data", 32'(rx_data), 32'hFF);

        // Abort after 5 bits, then a clean transfer.
        push_tx(8'h33);
        rv0 = rxv_cnt;
        start_xfer();
        spi_bits(8'hA0, 5);
        ss_n = 1'b1;
        clks(4);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_oe", 32'(miso_oe), 32'd0);
        check("abort_miso", 32'(miso), 32'd0);
        sclk = 1'b0;
        clks(10);
        check("abort_no_rxv", 32'(rxv_cnt), 32'(rv0));
        push_tx(8'h96);
        rx_q.push_back(8'h5A);
        tx_q.push_back(8'h96);
        start_xfer();
        spi_bits(8'h5A, 8);
        end_xfer();
        check("abort_next_rx", 32'(rx_data), 32'h5A);
        check("abort_underrun", 32'(un_cnt), 32'd1);

        // Reset mid-transfer.
        push_tx(8'h0F);
        start_xfer();
        spi_bits(8'hE0, 3);
        rst_n = 1'b0;
        #1;
        check("mrst_miso", 32'(miso), 32'd0);
        check("mrst_oe", 32'(miso_oe), 32'd0);
        check("mrst_tx_ready", 32'(tx_ready), 32'd1);
        check("mrst_rx_data", 32'(rx_data), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        ss_n = 1'b1;
        sclk = 1'b0;
        clks(3);
        rst_n = 1'b1;
        clks(5);
        check("mrst_idle", 32'(busy), 32'd0);
        push_tx(8'hE7);
        rx_q.push_back(8'hC3);
        tx_q.push_back(8'hE7);
        start_xfer();
        spi_bits(8'hC3, 8);
        end_xfer();
        check("mrst_rx", 32'(rx_data), 32'hC3);

        // Idle sclk toggles with ss_n high.
        push_tx(8'h44);
        rv0 = rxv_cnt;
        for (int i = 0; i < 16; i++) begin
            sclk = ~sclk;
            clks(5);
            if (miso_oe !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL idle_oe: got %0b, expected 0", miso_oe);
            end
        end
        clks(5);
        check("idle_no_rxv", 32'(rxv_cnt), 32'(rv0));
        check("idle_buf_kept", 32'(tx_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_underrun", 32'(un_cnt), 32'd1);

        check("rx_q_drained", 32'(rx_q.size()), 32'd0);
        check("tx_q_drained", 32'(tx_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
